// File: rtl/lvda_store_pkg.sv
// Shared definitions for the processor-store delay-line writer: phase encoding,
// writer state encoding and frame length (macro LVDA_STORE_PARITY_EN adds a parity bit).
package lvda_store_pkg;

  localparam logic [1:0] PH_W = 2'd0;
  localparam logic [1:0] PH_X = 2'd1;
  localparam logic [1:0] PH_Y = 2'd2;
  localparam logic [1:0] PH_Z = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } wr_state_t;

  function automatic int frame_bits(input int word_w);
`ifdef LVDA_STORE_PARITY_EN
    return word_w + 1;
`else
    return word_w;
`endif
  endfunction

endpackage

// File: rtl/lvda_store_bit_timer.sv
// Bit-time tracker for the interleaved delay line: counts bit positions per frame,
// resynchronises on WORD_SYNC and flags syncs that arrive at a non-zero bit position.
module lvda_store_bit_timer
  import lvda_store_pkg::*;
#(
  parameter int FRAME_BITS = 26,
  parameter int CNT_W      = $clog2(FRAME_BITS)
) (
  input  logic             SIM_CLK,
  input  logic             SIM_RST,
  input  logic             BIT_STB,
  input  logic [1:0]       PHASE,
  input  logic             WORD_SYNC,
  output logic [CNT_W-1:0] slot_bit,
  output logic             slot_synced,
  output logic             slot_misalign,
  output logic             SYNC_ERR
);

  logic [CNT_W-1:0] bitcnt;
  logic             sync_seen;
  logic             sync_slot;

  // A sync slot is bit 0 of the frame regardless of where the counter had drifted.
  assign sync_slot     = BIT_STB && WORD_SYNC && (PHASE == PH_W);
  assign slot_bit      = sync_slot ? '0 : bitcnt;
  assign slot_synced   = sync_seen || sync_slot;
  assign slot_misalign = sync_slot && (bitcnt != '0);

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      bitcnt    <= '0;
      sync_seen <= 1'b0;
      SYNC_ERR  <= 1'b0;
    end else begin
      SYNC_ERR <= slot_misalign;
      if (sync_slot) begin
        bitcnt    <= '0;
        sync_seen <= 1'b1;
      end else if (BIT_STB && (PHASE == PH_Z)) begin
        bitcnt <= (bitcnt == CNT_W'(FRAME_BITS - 1)) ? '0 : bitcnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/processor_store_writer.sv
// Write side of the processor-store delay line: serialises one word into its channel's
// slots, recirculating DLO everywhere else. LVDA_STORE_PARITY_EN appends an odd-parity bit.
module processor_store_writer
  import lvda_store_pkg::*;
#(
  parameter int WORD_W = 26
) (
  input  logic              SIM_CLK,
  input  logic              SIM_RST,
  input  logic              BIT_STB,
  input  logic [1:0]        PHASE,
  input  logic              WORD_SYNC,
  input  logic              DLO,
  input  logic              WR_REQ,
  input  logic [1:0]        WR_CH,
  input  logic [WORD_W-1:0] WR_DATA,
  output logic              WR_BUSY,
  output logic              WR_ACK,
  output logic              DINP,
  output logic              DINP_STB,
  output logic              SYNC_ERR
);

  localparam int FRAME_BITS = frame_bits(WORD_W);
  localparam int CNT_W      = $clog2(FRAME_BITS);
  localparam int LEFT_W     = $clog2(FRAME_BITS + 1);

  wr_state_t             state;
  logic [1:0]            ch_q;
  logic [FRAME_BITS-1:0] word_q;
  logic [FRAME_BITS-1:0] shreg;
  logic [FRAME_BITS-1:0] accept_word;
  logic [LEFT_W-1:0]     bits_left;
  logic [CNT_W-1:0]      slot_bit;
  logic                  slot_synced;
  logic                  slot_misalign;
  logic                  own_slot;
  logic                  start;
  logic                  insert;
  logic                  ins_bit;

  lvda_store_bit_timer #(
    .FRAME_BITS (FRAME_BITS),
    .CNT_W      (CNT_W)
  ) u_bit_timer (
    .SIM_CLK       (SIM_CLK),
    .SIM_RST       (SIM_RST),
    .BIT_STB       (BIT_STB),
    .PHASE         (PHASE),
    .WORD_SYNC     (WORD_SYNC),
    .slot_bit      (slot_bit),
    .slot_synced   (slot_synced),
    .slot_misalign (slot_misalign),
    .SYNC_ERR      (SYNC_ERR)
  );

`ifdef LVDA_STORE_PARITY_EN
  assign accept_word = {~^WR_DATA, WR_DATA};
`else
  assign accept_word = WR_DATA;
`endif

  // A misaligned sync in SHIFT restarts the retained word; for channel W that is this very slot.
  assign own_slot = BIT_STB && (PHASE == ch_q);
  assign start    = own_slot && slot_synced && (slot_bit == '0) &&
                    ((state == ARM) || ((state == SHIFT) && slot_misalign));
  assign insert   = start || (own_slot && (state == SHIFT) && !slot_misalign);
  assign ins_bit  = start ? word_q[0] : shreg[0];

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      state     <= IDLE;
      ch_q      <= '0;
      word_q    <= '0;
      shreg     <= '0;
      bits_left <= '0;
      WR_BUSY   <= 1'b0;
      WR_ACK    <= 1'b0;
      DINP      <= 1'b0;
      DINP_STB  <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so ins_bit above sees shreg as it was before this edge's shift.
      WR_ACK   <= 1'b0;
      DINP_STB <= BIT_STB;
      if (BIT_STB) DINP <= insert ? ins_bit : DLO;

      case (state)
        IDLE: begin
          if (WR_REQ) begin
            ch_q    <= WR_CH;
            word_q  <= accept_word;
            WR_BUSY <= 1'b1;
            state   <= ARM;
          end
        end
        ARM, SHIFT: begin
          if (start) begin
            shreg     <= word_q >> 1;
            bits_left <= LEFT_W'(FRAME_BITS - 1);
            state     <= SHIFT;
          end else if ((state == SHIFT) && slot_misalign) begin
            state <= ARM;
          end else if (insert) begin
            shreg     <= shreg >> 1;
            bits_left <= bits_left - LEFT_W'(1);
            if (bits_left == LEFT_W'(1)) begin
              WR_ACK  <= 1'b1;
              WR_BUSY <= 1'b0;
              state   <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
